rhs_stim_sequencer: RTL
=======================

Name: rhs_stim_sequencer

Overview:
- Sequences biphasic stimulation pulses on the RHS headstage. Sits between the AXI-Lite control register bank and the SPI command/frame engine.
- Latches the stim configuration at start, times phases in 50 us sample-frame ticks and issues stim commands over a valid/ready interface.
- Reports busy/done status back to the register bank (done maps to status bit 16).

Parameters:
- CNT_W, 16, width of pulse-width, delay and pulse-count config fields and counters
- CH_W, 5, channel index width

Ports:
- aclk  in  1  system clock; one clock domain
- areset  in  1  synchronous active-high reset
- tick_50us  in  1  one-cycle pulse from frame engine, once per 50 us sample frame
- stim_en  in  1  level from control reg bit 3; rising edge starts, falling edge aborts/clears
- cfg_pulse_width  in  CNT_W  per-phase width in ticks; 0 treated as 1
- cfg_intrapulse_delay  in  CNT_W  gap between pulses in ticks; 0 means no gap
- cfg_num_pulse  in  CNT_W  pulses issued = value+1
- cfg_pos_ch  in  CH_W  positive-electrode channel
- cfg_neg_ch  in  CH_W  negative-electrode channel
- cfg_mono  in  1  1 = drive pos channel only; 0 = bipolar
- cmd_valid  out  1  command request
- cmd_ready  in  1  frame engine accepts command
- cmd_code  out  2  0=OFF, 1=PHASE1, 2=PHASE2, 3 reserved (never issued)
- cmd_pos_ch  out  CH_W  latched pos channel
- cmd_neg_ch  out  CH_W  latched neg channel
- cmd_mono  out  1  latched mono flag
- stim_busy  out  1  sequence in progress
- stim_done  out  1  sequence completed normally
- pulse_cnt  out  CNT_W  pulses completed in current run

Behaviour:
- Reset (areset sampled high at aclk edge): state IDLE; all outputs 0; counters, latches and abort flag cleared; no OFF command issued.
- States: IDLE, CMD_P1, P1, CMD_P2, P2, CMD_OFF, GAP, DONE.
- IDLE: on stim_en 0->1, latch all cfg_* inputs, pulse_cnt=0, stim_busy=1, go to CMD_P1. Later cfg changes are ignored until the next start.
- CMD_x states: cmd_valid=1 with cmd_code and channels stable. Handshake completes when cmd_valid&&cmd_ready; next cycle moves to the timing state. cmd_valid never drops before acceptance.
- P1/P2: count tick_50us. Leave after max(pw,1) ticks: P1->CMD_P2, P2->CMD_OFF.
- CMD_OFF accepted:
  - pulse_cnt++.
  - If pulse_cnt (new value) = cfg_num_pulse+1: go to DONE.
  - Else if delay=0: go to CMD_P1.
  - Else: go to GAP.
- GAP: count delay ticks, then go to CMD_P1.
- Ticks arriving in CMD_x states are not counted. A tick in the same cycle as acceptance is not counted.
- Counters are CNT_W wide. The compare uses a CNT_W+1 wide pulse target, so cfg_num_pulse=0xFFFF yields 65536 pulses with no wrap.
- DONE: stim_busy=0, stim_done=1, held while stim_en=1. On stim_en=0, go to IDLE and clear stim_done. stim_en must fall and rise again to restart.
- Abort (stim_en=0 while busy):
  - From P1/P2/GAP: go to CMD_OFF next cycle.
  - From CMD_P1/CMD_P2: finish the pending handshake, then go to CMD_OFF.
  - From CMD_OFF: finish it.
  - After the abort OFF is accepted: go to IDLE with stim_done=0, busy=0. pulse_cnt holds its value until the next start.
- stim_en toggling 0->1 during abort does not restart; the sequencer must reach IDLE first.
- Bipolar/mono polarity is encoded by the frame engine from cmd_code plus channels; this block only forwards latched values.

Optional Feature:
- Macro RHS_STIM_INFINITE_EN.
- Defined: extra input cfg_infinite (1 bit, latched at start). When 1, pulse-count termination is disabled. Pulses repeat until abort, and pulse_cnt saturates at all-ones.
- Undefined: port absent; behaviour as above.

Test Plan:
- pw=1, delay=16, num_pulse=1, bipolar ch17/18, cmd_ready=1 -> commands P1,P2,OFF,P1,P2,OFF. P1->P2 spacing 1 tick, OFF->P1 spacing 16 ticks. stim_done=1, pulse_cnt=2; done clears one cycle after stim_en falls.
- cmd_ready held low 5 cycles on each command -> cmd_valid/code/channels stable throughout. Ticks during stall not counted; same command sequence results.
- Abort: stim_en falls mid-P2 of pulse 1 (pw=4) -> single OFF issued, then IDLE. stim_done=0, pulse_cnt=0.
- Config: cfg changed while busy (pw 1->8) -> timing unchanged. pw=0 behaves as 1; delay=0 gives CMD_OFF directly followed by CMD_P1.
- Reset: areset mid-GAP -> next cycle all outputs 0, state IDLE. A new stim_en rise runs a full sequence normally.
- RHS_STIM_INFINITE_EN: cfg_infinite=1, num_pulse=0 -> more than 10 pulses observed. Abort yields OFF then IDLE with stim_done=0.

Source files
------------

// File: rtl/rhs_stim_sequencer.sv
// Biphasic stimulation sequencer for the RHS headstage: latches the stim config on
// stim_en rise, times phases in 50 us ticks and issues commands. Optional: RHS_STIM_INFINITE_EN.
module rhs_stim_sequencer #(
  parameter int CNT_W = 16,
  parameter int CH_W  = 5
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             tick_50us,
  input  logic             stim_en,
  input  logic [CNT_W-1:0] cfg_pulse_width,
  input  logic [CNT_W-1:0] cfg_intrapulse_delay,
  input  logic [CNT_W-1:0] cfg_num_pulse,
  input  logic [CH_W-1:0]  cfg_pos_ch,
  input  logic [CH_W-1:0]  cfg_neg_ch,
  input  logic             cfg_mono,
`ifdef RHS_STIM_INFINITE_EN
  input  logic             cfg_infinite,
`endif
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_code,
  output logic [CH_W-1:0]  cmd_pos_ch,
  output logic [CH_W-1:0]  cmd_neg_ch,
  output logic             cmd_mono,
  output logic             stim_busy,
  output logic             stim_done,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD_P1  = 3'd1,
    P1      = 3'd2,
    CMD_P2  = 3'd3,
    P2      = 3'd4,
    CMD_OFF = 3'd5,
    GAP     = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             stim_en_q;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] pw_q, pw_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CH_W-1:0]  pos_q, pos_d;
  logic [CH_W-1:0]  neg_q, neg_d;
  logic             mono_q, mono_d;
  logic             inf_w;
  logic             abort_now;
  logic [CNT_W:0]   pulse_inc;
  logic [CNT_W:0]   pulse_target;

`ifdef RHS_STIM_INFINITE_EN
  logic inf_q, inf_d;
  assign inf_w = inf_q;
`else
  assign inf_w = 1'b0;
`endif

  // Abort is sticky once stim_en has dropped; a re-rise is ignored until IDLE.
  assign abort_now    = abort_q | ~stim_en;
  assign pulse_inc    = {1'b0, pulse_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign pulse_target = {1'b0, num_q} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      stim_en_q   <= 1'b0;
      abort_q     <= 1'b0;
      tick_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      pw_q        <= '0;
      delay_q     <= '0;
      num_q       <= '0;
      pos_q       <= '0;
      neg_q       <= '0;
      mono_q      <= 1'b0;
`ifdef RHS_STIM_INFINITE_EN
      inf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stim_en_q   <= stim_en;
      abort_q     <= abort_d;
      tick_cnt_q  <= tick_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      pw_q        <= pw_d;
      delay_q     <= delay_d;
      num_q       <= num_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      mono_q      <= mono_d;
`ifdef RHS_STIM_INFINITE_EN
      inf_q       <= inf_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    tick_cnt_d  = tick_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    pw_d        = pw_q;
    delay_d     = delay_q;
    num_d       = num_q;
    pos_d       = pos_q;
    neg_d       = neg_q;
    mono_d      = mono_q;
`ifdef RHS_STIM_INFINITE_EN
    inf_d       = inf_q;
`endif
    case (state_q)
      IDLE: begin
        if (stim_en && !stim_en_q) begin
          pw_d        = (cfg_pulse_width == '0) ? ONE : cfg_pulse_width;
          delay_d     = cfg_intrapulse_delay;
          num_d       = cfg_num_pulse;
          pos_d       = cfg_pos_ch;
          neg_d       = cfg_neg_ch;
          mono_d      = cfg_mono;
`ifdef RHS_STIM_INFINITE_EN
          inf_d       = cfg_infinite;
`endif
          pulse_cnt_d = '0;
          abort_d     = 1'b0;
          state_d     = CMD_P1;
        end
      end
      CMD_P1, CMD_P2: begin
        abort_d = abort_now;
        if (cmd_ready) begin
          tick_cnt_d = '0;
          if (abort_now)              state_d = CMD_OFF;
          else if (state_q == CMD_P1) state_d = P1;
          else                        state_d = P2;
        end
      end
      P1, P2, GAP: begin
        if (!stim_en) begin
          abort_d = 1'b1;
          state_d = CMD_OFF;
        end else if (tick_50us) begin
          if (tick_cnt_q == ((state_q == GAP) ? delay_q : pw_q) - ONE) begin
            tick_cnt_d = '0;
            if (state_q == P1)      state_d = CMD_P2;
            else if (state_q == P2) state_d = CMD_OFF;
            else                    state_d = CMD_P1;
          end else begin
            tick_cnt_d = tick_cnt_q + ONE;
          end
        end
      end
      CMD_OFF: begin
        abort_d = abort_now;
        if (cmd_ready) begin
          tick_cnt_d = '0;
          if (abort_now) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            // Infinite runs saturate the count instead of wrapping.
            if (!(inf_w && pulse_cnt_q == '1)) pulse_cnt_d = pulse_inc[CNT_W-1:0];
            if (!inf_w && pulse_inc == pulse_target) state_d = DONE;
            else if (delay_q == '0)                  state_d = CMD_P1;
            else                                     state_d = GAP;
          end
        end
      end
      DONE: begin
        if (!stim_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cmd_valid is raised only in CMD_* states and holds, with code and channels
  // stable, until the cycle where cmd_valid && cmd_ready completes the transfer.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_code  = 2'd0;
    stim_busy = 1'b0;
    stim_done = 1'b0;
    case (state_q)
      CMD_P1:  begin cmd_valid = 1'b1; cmd_code = 2'd1; stim_busy = 1'b1; end
      CMD_P2:  begin cmd_valid = 1'b1; cmd_code = 2'd2; stim_busy = 1'b1; end
      CMD_OFF: begin cmd_valid = 1'b1; cmd_code = 2'd0; stim_busy = 1'b1; end
      P1, P2, GAP: stim_busy = 1'b1;
      DONE:    stim_done = 1'b1;
      default: ;
    endcase
  end

  assign cmd_pos_ch = pos_q;
  assign cmd_neg_ch = neg_q;
  assign cmd_mono   = mono_q;
  assign pulse_cnt  = pulse_cnt_q;
  assign dbg_state  = state_q;

endmodule
